// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered arbitrating multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Upper bound on channel count the round-robin helper can scan.
    localparam int RR_MAX_IN = 32;
    localparam int RR_IDX_W  = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] index;
    } rr_pick_t;

    // First valid channel at or after ptr, wrapping modulo num.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_IN-1:0] valid,
                                         input int ptr,
                                         input int num);
        rr_pick_t res;
        int       idx;
        res = '0;
        for (int k = 0; k < RR_MAX_IN; k++) begin
            if (k < num) begin
                idx = ptr + k;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (!res.found && valid[idx[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.index = idx[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry FIFO with a registered in_ready, so upstream ready never
// depends combinationally on out_ready.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             rdy_q;
    logic             push;
    logic             pop;

    assign in_ready  = rdy_q;
    assign out_valid = (count != 2'd0);
    assign out_data  = rd_ptr ? mem1 : mem0;
    assign push      = in_valid && rdy_q;
    assign pop       = out_valid && out_ready;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // Storage, pointers and the registered ready (held low through reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            rdy_q  <= 1'b0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    mem1 <= in_data;
                end else begin
                    mem0 <= in_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
            rdy_q <= (count_next < 2'd2);
        end
    end

endmodule

// File: rtl/arb_mux_pipe.sv
// N-input registered mux: explicit-select or round-robin grant feeding a
// two-entry skid buffer that carries {source index, data}.
module arb_mux_pipe
    import mux_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_IN     = 4,
    localparam int SEL_W      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]             out_src,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic                  grant_found;
    logic [SEL_W-1:0]      grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [SEL_W-1:0]      rr_ptr;
    logic                  buf_ready;
    logic                  push;
    rr_pick_t              rr_res;
    logic [SEL_W+DATA_WIDTH-1:0] buf_out;

    assign rr_res = rr_pick(RR_MAX_IN'(in_valid), int'(rr_ptr), NUM_IN);

    // Grant selection; sel values past the last channel match nothing.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (mode_e'(mode) == MODE_RR) begin
                if (rr_res.found && rr_res.index == RR_IDX_W'(i)) begin
                    grant_found = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end else begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = SEL_W'(i);
                end
            end
        end
    end

    // Slice out the granted channel's data and drive the one-hot ready.
    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                in_ready[i] = buf_ready && grant_found;
            end
        end
    end

    assign push = grant_found && buf_ready;

    // Round-robin pointer advances past the winner only on RR-mode pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (push && mode_e'(mode) == MODE_RR) begin
            rr_ptr <= (grant_idx == SEL_W'(NUM_IN-1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    skid_buffer #(
        .WIDTH(SEL_W + DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  ({grant_idx, grant_data}),
        .in_valid (grant_found),
        .in_ready (buf_ready),
        .out_data (buf_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_src  = buf_out[SEL_W+DATA_WIDTH-1:DATA_WIDTH];
    assign out_data = buf_out[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_arb_mux_pipe.sv
// Bench for arb_mux_pipe: vector table plus scoreboard of {src, data}.
module tb_arb_mux_pipe;
    import mux_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Four-channel instance
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic            mode;
    logic [1:0]      sel;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_valid;
    logic            out_ready;

    // Three-channel instance (non power of two)
    logic [3*DW-1:0] in_data3;
    logic [2:0]      in_valid3;
    logic [2:0]      in_ready3;
    logic            mode3;
    logic [1:0]      sel3;
    logic [DW-1:0]   out_data3;
    logic [1:0]      out_src3;
    logic            out_valid3;
    logic            out_ready3;

    arb_mux_pipe #(.DATA_WIDTH(DW), .NUM_IN(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
    );

    arb_mux_pipe #(.DATA_WIDTH(DW), .NUM_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    int total = 0;
    int bad   = 0;
    int kstep = 0;
    int m_count = 0;
    logic [33:0] sb[$];

    typedef struct {
        logic       md;
        logic [1:0] sl;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        string      name;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [4*DW-1:0] pat(input int k);
        logic [4*DW-1:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i*DW +: DW] = 32'hC000_0000 | (32'(i) << 24) | (32'(k & 255) << 8) | 32'(i);
        end
        return v;
    endfunction

    function automatic logic [4*DW-1:0] a5vec(input logic [31:0] w2);
        logic [4*DW-1:0] v;
        for (int i = 0; i < 4; i++) begin
            v[i*DW +: DW] = 32'h1111_0000 + 32'(i);
        end
        v[2*DW +: DW] = w2;
        return v;
    endfunction

    // One cycle: drive at negedge, check ready and buffer head, update model.
    task automatic step(input logic md, input logic [1:0] sl, input logic [3:0] vld,
                        input logic ordy, input logic [4*DW-1:0] d,
                        input logic [3:0] exp_rdy, input string nm);
        logic [33:0] head;
        int          pushed;
        @(negedge clk);
        mode = md; sel = sl; in_valid = vld; out_ready = ordy; in_data = d;
        kstep++;
        #1;
        chk({nm, " in_ready"}, 64'(in_ready), 64'(exp_rdy));
        chk({nm, " out_valid"}, 64'(out_valid), 64'(m_count > 0));
        if (m_count > 0) begin
            head = sb[0];
            chk({nm, " out_data"}, 64'(out_data), 64'(head[31:0]));
            chk({nm, " out_src"}, 64'(out_src), 64'(head[33:32]));
            if (ordy) begin
                void'(sb.pop_front());
                m_count--;
            end
        end
        pushed = 0;
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && exp_rdy[i] && pushed == 0) begin
                sb.push_back({2'(i), d[i*DW +: DW]});
                pushed = 1;
            end
        end
        m_count += pushed;
    endtask

    initial begin
        in_data = '0; in_valid = 4'b1111; mode = MODE_SEL; sel = '0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = '0; mode3 = MODE_SEL; sel3 = '0; out_ready3 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", 64'(out_data), 64'd0);
        chk("rst out_src", 64'(out_src), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = '0;
        rst_n = 1'b1;

        // Three channels: out-of-range sel grants nothing, then sel=1 transfers
        @(negedge clk);
        mode3 = MODE_SEL; sel3 = 2'd3; in_valid3 = 3'b111;
        for (int i = 0; i < 3; i++) in_data3[i*DW +: DW] = 32'h3300_0000 + 32'(i);
        #1;
        chk("n3 sel3 in_ready", 64'(in_ready3), 64'd0);
        @(negedge clk);
        #1;
        chk("n3 sel3 no push", 64'(out_valid3), 64'd0);
        sel3 = 2'd1;
        #1;
        chk("n3 sel1 in_ready", 64'(in_ready3), 64'b010);
        @(negedge clk);
        in_valid3 = '0;
        #1;
        chk("n3 out_valid", 64'(out_valid3), 64'd1);
        chk("n3 out_data", 64'(out_data3), 64'h3300_0001);
        chk("n3 out_src", 64'(out_src3), 64'd1);

        // Explicit select of channel 2, one-cycle latency, continuous streaming
        step(MODE_SEL, 2'd2, 4'b1111, 1'b1, a5vec(32'hA5A5_0002), 4'b0100, "sel2_a");
        @(posedge clk);
        #1;
        chk("sel2 latency data", 64'(out_data), 64'hA5A5_0002);
        chk("sel2 latency src", 64'(out_src), 64'd2);
        step(MODE_SEL, 2'd2, 4'b1111, 1'b1, a5vec(32'hA5A5_1002), 4'b0100, "sel2_b");
        step(MODE_SEL, 2'd2, 4'b1111, 1'b1, a5vec(32'hA5A5_2002), 4'b0100, "sel2_c");
        step(MODE_SEL, 2'd0, 4'b0000, 1'b1, '0, 4'b0000, "sel2_drain");

        // Vector table
        vt.push_back('{MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr_all_0"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr_all_1"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0100, "rr_all_2"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b1000, "rr_all_3"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr_all_4"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0010, "rr_all_5"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1000, 1'b1, 4'b1000, "rr_to_ptr0"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, "rr_1010_a"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000, "rr_1010_b"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b0010, "rr_1010_c"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1010, 1'b1, 4'b1000, "rr_1010_d"});
        vt.push_back('{MODE_SEL, 2'd2, 4'b1111, 1'b1, 4'b0100, "sel_keep_a"});
        vt.push_back('{MODE_SEL, 2'd2, 4'b1111, 1'b1, 4'b0100, "sel_keep_b"});
        vt.push_back('{MODE_SEL, 2'd2, 4'b1111, 1'b1, 4'b0100, "sel_keep_c"});
        vt.push_back('{MODE_RR, 2'd0, 4'b1111, 1'b1, 4'b0001, "rr_after_sel"});
        vt.push_back('{MODE_SEL, 2'd0, 4'b0001, 1'b0, 4'b0001, "bp_fill"});
        vt.push_back('{MODE_SEL, 2'd0, 4'b0001, 1'b0, 4'b0000, "bp_full_a"});
        vt.push_back('{MODE_SEL, 2'd0, 4'b0001, 1'b0, 4'b0000, "bp_full_b"});
        vt.push_back('{MODE_SEL, 2'd0, 4'b0001, 1'b0, 4'b0000, "bp_full_c"});
        vt.push_back('{MODE_SEL, 2'd0, 4'b0001, 1'b1, 4'b0000, "bp_release"});
        vt.push_back('{MODE_SEL, 2'd0, 4'b0001, 1'b1, 4'b0001, "bp_resume"});
        vt.push_back('{MODE_SEL, 2'd0, 4'b0000, 1'b1, 4'b0000, "bp_drain_a"});
        vt.push_back('{MODE_SEL, 2'd0, 4'b0000, 1'b1, 4'b0000, "bp_drain_b"});
        for (int r = 0; r < vt.size(); r++) begin
            step(vt[r].md, vt[r].sl, vt[r].vld, vt[r].ordy, pat(kstep),
                 vt[r].exp_rdy, vt[r].name);
        end
        chk("table drained", 64'(sb.size()), 64'd0);

        // Reset with the buffer full
        step(MODE_SEL, 2'd0, 4'b0001, 1'b0, pat(kstep), 4'b0001, "mr_fill_a");
        step(MODE_SEL, 2'd0, 4'b0001, 1'b0, pat(kstep), 4'b0001, "mr_fill_b");
        step(MODE_SEL, 2'd0, 4'b1111, 1'b0, pat(kstep), 4'b0000, "mr_full");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr out_valid", 64'(out_valid), 64'd0);
        chk("mr in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        m_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr out_data", 64'(out_data), 64'd0);
        chk("mr out_src", 64'(out_src), 64'd0);
        chk("mr out_valid post", 64'(out_valid), 64'd0);
        step(MODE_SEL, 2'd1, 4'b0000, 1'b1, pat(kstep), 4'b0000, "mr_idle");
        step(MODE_SEL, 2'd1, 4'b0010, 1'b1, pat(kstep), 4'b0010, "mr_recover");
        step(MODE_SEL, 2'd1, 4'b0000, 1'b1, pat(kstep), 4'b0000, "mr_pop");
        chk("mr drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
